pca9635_target: RTL
===================

Name: pca9635_target

Overview:
I2C target (responder) that emulates the register file of a PCA9635 16-channel LED driver. It lets simulation benches and FPGA loopback builds terminate the LED master's I2C stream without a physical PCA9635. It decodes START, STOP, address, control/pointer and data bytes, and updates a 28-byte register file. It exposes the decoded PWM and LEDOUT state as parallel outputs and pulses a write strobe per accepted byte.

Parameters:
ADDR, 7'h5B, 7-bit target address matched against the first byte after START.
NUM_REGS, 28, number of implemented registers (0x00..0x1B); pointer wraps at NUM_REGS.
MODE1_RST, 8'h11, reset value of register 0x00 (MODE1); all other registers reset to 8'h00 except MODE2=8'h05.

Ports:
clk  in  1  system clock; must be at least 16x the SCL frequency.
rst  in  1  asynchronous, active-low reset.
scl_i  in  1  raw SCL pad input (asynchronous).
sda_i  in  1  raw SDA pad input (asynchronous).
scl_oe  out  1  SCL pull-down enable; tied 0 (no clock stretching).
sda_oe  out  1  SDA pull-down enable; 1 = drive low.
led_pwm  out  128  PWM0..PWM15 (regs 0x02..0x11); led_pwm[8i+7:8i] = PWMi.
led_out  out  32  LEDOUT0..3 (regs 0x14..0x17) concatenated; 2 bits per LED.
wr_stb  out  1  one-clk pulse per register byte written.
wr_addr  out  5  register index of the current wr_stb.
wr_data  out  8  data of the current wr_stb.
busy  out  1  high from an address-matched START until the next STOP.

Behaviour:
- Reset (rst=0): all state goes to IDLE; sda_oe=0, scl_oe=0, wr_stb=0, busy=0; registers return to their reset values; pointer=0; autoinc=0.
- Input path: 2-FF synchronizer on scl_i/sda_i, plus one history FF. SCL rise/fall and SDA edges are decoded from the synced and history values.
- START (repeated START included): SDA falls while SCL is high. It is valid in any state and moves to ADDR with the bit counter cleared. STOP: SDA rises while SCL is high. It moves to IDLE from any state, releases sda_oe and clears busy.
- Bit timing: SDA is sampled on SCL rise; sda_oe changes only on SCL fall. Bytes are MSB first, 8 bits.
- FSM: IDLE -> ADDR -> ADDR_ACK -> CTRL -> CTRL_ACK -> WDATA <-> WDATA_ACK. The read path is RDATA <-> RDATA_MACK (see Optional Feature).
- ADDR: after 8 bits, compare bits[7:1] with ADDR.
  - Match and R/W=0: drive ACK on the next SCL fall and set busy.
  - Mismatch: go to IDLE without driving, and ignore the bus until the next START.
- ACK slots: sda_oe=1 from the SCL fall after bit 0 until the SCL fall that ends the 9th clock, then released.
- CTRL byte: pointer = byte[4:0] and autoinc = byte[7]; bits[6:5] are ignored. The byte is always ACKed.
- WDATA byte:
  - If pointer < NUM_REGS, write the register and pulse wr_stb on the clk cycle after the 8th-bit sample, with wr_addr/wr_data valid for that same cycle.
  - If pointer >= NUM_REGS, discard the data without a strobe but still ACK it.
- Pointer update after each data byte: if autoinc, pointer = (pointer+1 == NUM_REGS) ? 0 : pointer+1; otherwise it is unchanged.
- led_pwm and led_out are direct views of the register file and update on the same cycle as wr_stb.
- Repeated START preserves pointer and autoinc. STOP preserves them too; only reset clears them.
- START/STOP mid-byte: the partial byte is dropped and no write occurs.
- Reset mid-transaction releases SDA immediately (asynchronous clear).

Optional Feature:
Macro PCA9635_TARGET_READ_EN.
- Defined:
  - An address with R/W=1 is ACKed, then the FSM enters RDATA.
  - Drive register[pointer] MSB first: sda_oe = ~bit, changed on SCL fall, first bit driven on the SCL fall ending the ACK clock.
  - Out-of-range pointer reads 8'hFF.
  - In RDATA_MACK, sample the master's ACK: ACK -> next byte with the pointer update rule; NACK -> release and wait for STOP/START.
- Not defined: R/W=1 addresses are NACKed and ignored; the RDATA states are not synthesized.

Decomposition:
- Package pca9635_pkg holds:
  - register index localparams (MODE1=0x00, MODE2=0x01, PWM0=0x02, GRPPWM=0x12, GRPFREQ=0x13, LEDOUT0=0x14, SUBADR1=0x18, ALLCALLADR=0x1B);
  - reset-value constants;
  - the FSM state enum.
- Sub-module i2c_bus_monitor: synchronizer plus SCL rise/fall and START/STOP pulse generation. It is shared with future I2C targets.

Test Plan:
- Master writes 0x5B<<1 | 0, 0x80, 0x11, 0x05, then 16 PWM bytes 0x00..0xF0 step 0x10, then STOP -> all bytes ACKed; 18 wr_stb pulses at addrs 0..17; led_pwm[15:8]=0x10; busy falls after STOP.
- Address 0x5A -> 9th-clock SDA stays high (NACK); no wr_stb; registers unchanged.
- Control 0x9A (AI, ptr 0x1A), 4 data bytes -> writes at 0x1A, 0x1B, 0x00, 0x01 (wrap).
- Control 0x02 (no AI), bytes 0x33, 0x44 -> PWM0 ends at 0x44; PWM1 unchanged.
- STOP after 5 bits of a data byte -> no wr_stb; next transaction behaves normally. rst asserted mid-ACK -> sda_oe=0 within the same cycle; MODE1 reads 0x11 after release.
- With PCA9635_TARGET_READ_EN: write ptr 0x82, repeated START with R/W=1, master ACK then NACK -> returns PWM0 and PWM1 values; SDA is released after the NACK.

Source files
------------

// File: rtl/pca9635_pkg.sv
// Shared definitions for the PCA9635 register-file target: register map,
// reset values, protocol FSM states and the pointer advance helper.
package pca9635_pkg;

  localparam logic [4:0] REG_MODE1      = 5'h00;
  localparam logic [4:0] REG_MODE2      = 5'h01;
  localparam logic [4:0] REG_PWM0       = 5'h02;
  localparam logic [4:0] REG_GRPPWM     = 5'h12;
  localparam logic [4:0] REG_GRPFREQ    = 5'h13;
  localparam logic [4:0] REG_LEDOUT0    = 5'h14;
  localparam logic [4:0] REG_SUBADR1    = 5'h18;
  localparam logic [4:0] REG_ALLCALLADR = 5'h1B;

  localparam int         NUM_REGS_DEF  = int'(REG_ALLCALLADR) + 1;
  localparam logic [7:0] MODE1_RST_DEF = 8'h11;
  localparam logic [7:0] MODE2_RST     = 8'h05;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_CTRL,
    ST_CTRL_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_MACK
  } state_e;

  function automatic logic [7:0] reg_rst(input int idx, input logic [7:0] mode1_rst);
    if (idx == int'(REG_MODE1)) return mode1_rst;
    if (idx == int'(REG_MODE2)) return MODE2_RST;
    return 8'h00;
  endfunction

  // Pointer wraps at the register count; values past it only wrap via the 5-bit field.
  function automatic logic [4:0] ptr_next(input logic [4:0] ptr, input int num_regs);
    logic [4:0] inc;
    inc = ptr + 5'd1;
    return (int'(inc) == num_regs) ? 5'd0 : inc;
  endfunction

endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronises raw SCL/SDA and decodes SCL edges plus START/STOP conditions.
// Event pulses trail the pads by two clk cycles; observation only, no backpressure.
module i2c_bus_monitor (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  // [0],[1] form the synchroniser, [2] is the history stage.
  logic [2:0] scl_q, scl_d;
  logic [2:0] sda_q, sda_d;

  always_comb begin
    scl_d = {scl_q[1:0], scl_i};
    sda_d = {sda_q[1:0], sda_i};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= scl_d;
      sda_q <= sda_d;
    end
  end

  assign sda_s    = sda_q[1];
  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign start    = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
  assign stop     = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];

endmodule

// File: rtl/pca9635_target.sv
// I2C target emulating the PCA9635 register file; wr_stb fires one clk after the 8th data bit.
// Never stretches SCL. Define PCA9635_TARGET_READ_EN to add the register read path.
module pca9635_target
  import pca9635_pkg::*;
#(
  parameter logic [6:0] ADDR      = 7'h5B,
  parameter int         NUM_REGS  = NUM_REGS_DEF,
  parameter logic [7:0] MODE1_RST = MODE1_RST_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         scl_i,
  input  logic         sda_i,
  output logic         scl_oe,
  output logic         sda_oe,
  output logic [127:0] led_pwm,
  output logic [31:0]  led_out,
  output logic         wr_stb,
  output logic [4:0]   wr_addr,
  output logic [7:0]   wr_data,
  output logic         busy
);

  logic sda_s, scl_rise, scl_fall, start, stop;

  i2c_bus_monitor u_mon (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  state_e                    state_q, state_d;
  logic [3:0]                bit_cnt_q, bit_cnt_d;
  logic [6:0]                shreg_q, shreg_d;
  logic                      sda_oe_q, sda_oe_d;
  logic                      busy_q, busy_d;
  logic [4:0]                ptr_q, ptr_d;
  logic                      autoinc_q, autoinc_d;
  logic [NUM_REGS-1:0][7:0]  regs_q, regs_d;
  logic                      wr_stb_q, wr_stb_d;
  logic [4:0]                wr_addr_q, wr_addr_d;
  logic [7:0]                wr_data_q, wr_data_d;
  logic [7:0]                byte_in;
  logic                      addr_ok;
`ifdef PCA9635_TARGET_READ_EN
  logic                      rw_q, rw_d;
  logic                      mack_q, mack_d;
  logic [7:0]                rd_q, rd_d;
  logic [4:0]                ptr_adv;
  logic [7:0]                rd_cur, rd_nxt;
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    ptr_d     = ptr_q;
    autoinc_d = autoinc_q;
    regs_d    = regs_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    byte_in   = {shreg_q, sda_s};
`ifdef PCA9635_TARGET_READ_EN
    rw_d    = rw_q;
    mack_d  = mack_q;
    rd_d    = rd_q;
    ptr_adv = autoinc_q ? ptr_next(ptr_q, NUM_REGS) : ptr_q;
    rd_cur  = (int'(ptr_q) < NUM_REGS) ? regs_q[ptr_q] : 8'hFF;
    rd_nxt  = (int'(ptr_adv) < NUM_REGS) ? regs_q[ptr_adv] : 8'hFF;
    addr_ok = (byte_in[7:1] == ADDR);
`else
    addr_ok = (byte_in[7:1] == ADDR) && !byte_in[0];
`endif

    if (stop) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_CTRL, ST_WDATA: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shreg_d   = byte_in[6:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              if (state_q == ST_ADDR) begin
                if (!addr_ok) state_d = ST_IDLE;
`ifdef PCA9635_TARGET_READ_EN
                rw_d = byte_in[0];
`endif
              end else if (state_q == ST_CTRL) begin
                ptr_d     = byte_in[4:0];
                autoinc_d = byte_in[7];
              end else begin
                if (int'(ptr_q) < NUM_REGS) begin
                  regs_d[ptr_q] = byte_in;
                  wr_stb_d      = 1'b1;
                  wr_addr_d     = ptr_q;
                  wr_data_d     = byte_in;
                end
                if (autoinc_q) ptr_d = ptr_next(ptr_q, NUM_REGS);
              end
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            sda_oe_d = 1'b1;
            if (state_q == ST_ADDR) busy_d = 1'b1;
            state_d = (state_q == ST_ADDR) ? ST_ADDR_ACK :
                      (state_q == ST_CTRL) ? ST_CTRL_ACK : ST_WDATA_ACK;
          end
        end
        ST_ADDR_ACK, ST_CTRL_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            state_d   = (state_q == ST_ADDR_ACK) ? ST_CTRL : ST_WDATA;
`ifdef PCA9635_TARGET_READ_EN
            if (state_q == ST_ADDR_ACK && rw_q) begin
              state_d  = ST_RDATA;
              rd_d     = rd_cur;
              sda_oe_d = ~rd_cur[7];
            end
`endif
          end
        end
`ifdef PCA9635_TARGET_READ_EN
        // rd_q[7] always holds the bit currently on the bus.
        ST_RDATA: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              state_d  = ST_RDATA_MACK;
            end else begin
              rd_d     = {rd_q[6:0], 1'b0};
              sda_oe_d = ~rd_q[6];
            end
          end
        end
        ST_RDATA_MACK: begin
          if (scl_rise) begin
            mack_d = ~sda_s;
          end else if (scl_fall) begin
            if (mack_q) begin
              ptr_d     = ptr_adv;
              rd_d      = rd_nxt;
              sda_oe_d  = ~rd_nxt[7];
              bit_cnt_d = 4'd0;
              state_d   = ST_RDATA;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 4'd0;
      shreg_q   <= 7'd0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      ptr_q     <= 5'd0;
      autoinc_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= reg_rst(i, MODE1_RST);
      wr_stb_q  <= 1'b0;
      wr_addr_q <= 5'd0;
      wr_data_q <= 8'd0;
`ifdef PCA9635_TARGET_READ_EN
      rw_q      <= 1'b0;
      mack_q    <= 1'b0;
      rd_q      <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      ptr_q     <= ptr_d;
      autoinc_q <= autoinc_d;
      regs_q    <= regs_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
`ifdef PCA9635_TARGET_READ_EN
      rw_q      <= rw_d;
      mack_q    <= mack_d;
      rd_q      <= rd_d;
`endif
    end
  end

  assign scl_oe  = 1'b0;
  assign sda_oe  = sda_oe_q;
  assign busy    = busy_q;
  assign wr_stb  = wr_stb_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign led_pwm = regs_q[REG_GRPPWM - 5'd1 : REG_PWM0];
  assign led_out = regs_q[REG_SUBADR1 - 5'd1 : REG_LEDOUT0];

endmodule
